// File: rtl/bcd_timer_chain_pkg.sv
// bcd_timer_chain_pkg: shared digit width, default MM:SS modulus vector and digit helpers.
package bcd_timer_chain_pkg;
    localparam int BCD_W = 4;
    localparam logic [15:0] DEF_MODS = 16'hAA6A;
    typedef logic [BCD_W-1:0] bcd_t;
    function automatic bcd_t mod_max(input int m);
        return BCD_W'(m - 1);
    endfunction
    function automatic bcd_t clamp_bcd(input bcd_t v, input bcd_t lim);
        return v > lim ? lim : v;
    endfunction
endpackage

// File: rtl/bcd_timer_chain_if.sv
// bcd_timer_chain_if: load/count controls and counter status between control logic and the timer.
interface bcd_timer_chain_if #(parameter int NDIG = 4);
    logic loadn;
    logic [4*NDIG-1:0] data;
    logic en;
    logic up;
    logic [4*NDIG-1:0] digits;
    logic zero;
    logic tc;
    logic done;
    logic load_err;
    modport master(output loadn, data, en, up, input digits, zero, tc, done, load_err);
    modport slave(input loadn, data, en, up, output digits, zero, tc, done, load_err);
endinterface

// File: rtl/bcd_timer_chain_digit.sv
// bcd_digit: one modulo-MOD BCD digit with clamped parallel load and up/down stepping.
module bcd_digit
    import bcd_timer_chain_pkg::*;
#(
    parameter int MOD = 10
) (
    input  logic clock,
    input  logic clearn,
    input  logic loadn,
    input  bcd_t d,
    input  logic step,
    input  logic up,
    output bcd_t q,
    output logic at_min,
    output logic at_max,
    output logic clamped
);
    localparam bcd_t LIM = mod_max(MOD);
    bcd_t eff, nxt;
    // an out-of-range register value behaves exactly like the maximum digit
    always_comb begin
        eff = clamp_bcd(q, LIM);
        nxt = up ? (eff == LIM ? '0 : eff + 1'b1) : (eff == '0 ? LIM : eff - 1'b1);
    end
    assign at_min = q == '0;
    assign at_max = eff == LIM;
    assign clamped = d > LIM;
    always_ff @(posedge clock or negedge clearn)
        if (!clearn) q <= '0;
        else if (!loadn) q <= clamp_bcd(d, LIM);
        else if (step) q <= nxt;
endmodule

// File: rtl/bcd_timer_chain.sv
// bcd_timer_chain: N-digit mixed-modulus BCD up/down timer with terminal hold/wrap and done pulse.
module bcd_timer_chain
    import bcd_timer_chain_pkg::*;
#(
    parameter int NDIG = 4,
    parameter logic [4*NDIG-1:0] DIGIT_MODS = DEF_MODS,
    parameter bit WRAP = 1'b0
) (
    input  logic clock,
    input  logic clearn,
    bcd_timer_chain_if.slave bus
);
    localparam bcd_t M0 = DIGIT_MODS[BCD_W-1:0];
    localparam logic [NDIG-1:0] LSB = NDIG'(1);
    logic [4*NDIG-1:0] q;
    logic [NDIG-1:0] at_min, at_max, clamped, step;
    logic term, hold, near, done_q, load_err_q;
    genvar g;
    generate
        for (g = 0; g < NDIG; g++) begin : dig
            bcd_digit #(.MOD(int'(DIGIT_MODS[BCD_W*g +: BCD_W]))) u_digit (
                .clock(clock),
                .clearn(clearn),
                .loadn(bus.loadn),
                .d(bus.data[BCD_W*g +: BCD_W]),
                .step(step[g]),
                .up(bus.up),
                .q(q[BCD_W*g +: BCD_W]),
                .at_min(at_min[g]),
                .at_max(at_max[g]),
                .clamped(clamped[g])
            );
        end
    endgenerate
    assign term = bus.up ? &at_max : &at_min;
    assign hold = !WRAP && term;
    // one step away from terminal: digit 0 one off its end, all higher digits already there
    assign near = bus.up ? (&(at_max | LSB) && q[BCD_W-1:0] == M0 - 4'd2)
                         : (&(at_min | LSB) && q[BCD_W-1:0] == 4'd1);
    always_comb begin
        step[0] = bus.en & ~hold;
        for (int i = 1; i < NDIG; i++) step[i] = step[i-1] & (bus.up ? at_max[i-1] : at_min[i-1]);
    end
    always_ff @(posedge clock or negedge clearn)
        if (!clearn) begin
            done_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            done_q <= bus.loadn & bus.en & ~term & near;
            load_err_q <= ~bus.loadn & |clamped;
        end
    assign bus.digits = q;
    assign bus.zero = ~|q;
    assign bus.tc = bus.en & term;
    assign bus.done = done_q;
    assign bus.load_err = load_err_q;
endmodule

// File: tb/tb_bcd_timer_chain.sv
// tb_bcd_timer_chain: hold and wrap variants checked against a mixed-radix integer model.
module tb_bcd_timer_chain;
    localparam int MODS[4] = '{10, 6, 10, 10};
    localparam int TOT = 6000;
    int errors = 0, checks = 0;
    logic clock = 1'b0, clearn = 1'b1, loadn = 1'b1, en = 1'b0, up = 1'b0;
    logic [15:0] data = '0;
    int n[2];
    bit ed[2], el[2];

    bcd_timer_chain_if #(.NDIG(4)) b0 ();
    bcd_timer_chain_if #(.NDIG(4)) b1 ();
    assign b0.loadn = loadn;
    assign b0.data = data;
    assign b0.en = en;
    assign b0.up = up;
    assign b1.loadn = loadn;
    assign b1.data = data;
    assign b1.en = en;
    assign b1.up = up;

    bcd_timer_chain #(.NDIG(4), .DIGIT_MODS(16'hAA6A), .WRAP(1'b0)) dut0 (.clock(clock), .clearn(clearn), .bus(b0));
    bcd_timer_chain #(.NDIG(4), .DIGIT_MODS(16'hAA6A), .WRAP(1'b1)) dut1 (.clock(clock), .clearn(clearn), .bus(b1));

    always #5 clock = ~clock;

    function automatic int to_n(input logic [15:0] v);
        int r = 0, w = 1;
        for (int i = 0; i < 4; i++) begin
            r += int'(v[4*i +: 4]) * w;
            w *= MODS[i];
        end
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % MODS[i]);
            v /= MODS[i];
        end
        return r;
    endfunction

    function automatic bit exp_tc(input int w);
        return en && n[w] == (up ? TOT - 1 : 0);
    endfunction

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            n[w] = 0;
            ed[w] = 0;
            el[w] = 0;
        end
    endtask

    task automatic model_step();
        logic [15:0] c;
        bit clip;
        int term;
        for (int w = 0; w < 2; w++) begin
            if (!loadn) begin
                clip = 0;
                for (int i = 0; i < 4; i++) begin
                    c[4*i +: 4] = int'(data[4*i +: 4]) > MODS[i] - 1 ? 4'(MODS[i] - 1) : data[4*i +: 4];
                    if (int'(data[4*i +: 4]) > MODS[i] - 1) clip = 1;
                end
                n[w] = to_n(c);
                el[w] = clip;
                ed[w] = 0;
            end else begin
                el[w] = 0;
                ed[w] = 0;
                term = up ? TOT - 1 : 0;
                if (en) begin
                    if (n[w] == term) begin
                        if (w == 1) n[w] = up ? 0 : TOT - 1;
                    end else begin
                        n[w] = up ? n[w] + 1 : n[w] - 1;
                        ed[w] = n[w] == term;
                    end
                end
            end
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clearn = 1'b0;
        model_reset();
        #1;
        checks++;
        if (b0.digits !== 16'h0000 || b0.zero !== 1'b1 || b0.done !== 1'b0 || b0.load_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_init digits=%h zero=%b done=%b le=%b exp 0000/1/0/0", b0.digits, b0.zero, b0.done, b0.load_err);
        end
        @(negedge clock);
        clearn = 1'b1;
        loadn = 1'b0; data = 16'h0123; en = 1'b1; up = 1'b0;
        cyc();
        loadn = 1'b1;
        cyc();
        cyc();
        checks++;
        if (b0.digits !== 16'h0121) begin
            errors++;
            $display("FAIL reset_precount digits=%h exp 0121", b0.digits);
        end
        clearn = 1'b0;
        model_reset();
        #1;
        checks++;
        if (b0.digits !== 16'h0000 || b0.zero !== 1'b1 || b0.done !== 1'b0 || b1.digits !== 16'h0000) begin
            errors++;
            $display("FAIL reset_midcount digits=%h/%h zero=%b done=%b exp 0000 zero=1 done=0", b0.digits, b1.digits, b0.zero, b0.done);
        end
        @(negedge clock);
        clearn = 1'b1;
        up = 1'b1;
        cyc();
        checks++;
        if (b0.digits !== 16'h0001 || b1.digits !== 16'h0001) begin
            errors++;
            $display("FAIL reset_resume digits=%h/%h exp 0001", b0.digits, b1.digits);
        end
    endtask

    task automatic test_borrow();
        loadn = 1'b0; data = 16'h1000; en = 1'b0;
        cyc();
        loadn = 1'b1; en = 1'b1; up = 1'b0;
        cyc();
        checks++;
        if (b0.digits !== 16'h0959) begin
            errors++;
            $display("FAIL borrow_first digits=%h exp 0959", b0.digits);
        end
        cyc();
        checks++;
        if (b0.digits !== 16'h0958 || b0.done !== 1'b0) begin
            errors++;
            $display("FAIL borrow_second digits=%h done=%b exp 0958 done=0", b0.digits, b0.done);
        end
    endtask

    task automatic test_hold();
        loadn = 1'b0; data = 16'h0002; en = 1'b1; up = 1'b0;
        cyc();
        loadn = 1'b1;
        cyc();
        checks++;
        if (b0.digits !== 16'h0001 || b0.done !== 1'b0 || b0.tc !== 1'b0) begin
            errors++;
            $display("FAIL hold_one digits=%h done=%b tc=%b exp 0001/0/0", b0.digits, b0.done, b0.tc);
        end
        cyc();
        checks++;
        if (b0.digits !== 16'h0000 || b0.done !== 1'b1 || b0.tc !== 1'b1 || b1.done !== 1'b1) begin
            errors++;
            $display("FAIL hold_reach digits=%h done=%b tc=%b wdone=%b exp 0000/1/1/1", b0.digits, b0.done, b0.tc, b1.done);
        end
        cyc();
        checks++;
        if (b0.digits !== 16'h0000 || b0.done !== 1'b0 || b0.tc !== 1'b1) begin
            errors++;
            $display("FAIL hold_stay digits=%h done=%b tc=%b exp 0000/0/1", b0.digits, b0.done, b0.tc);
        end
        checks++;
        if (b1.digits !== 16'h9959 || b1.done !== 1'b0) begin
            errors++;
            $display("FAIL wrap_down digits=%h done=%b exp 9959/0", b1.digits, b1.done);
        end
    endtask

    task automatic test_wrap();
        loadn = 1'b0; data = 16'h9958; en = 1'b1; up = 1'b1;
        cyc();
        loadn = 1'b1;
        cyc();
        checks++;
        if (b0.digits !== 16'h9959 || b0.done !== 1'b1 || b1.digits !== 16'h9959 || b1.done !== 1'b1) begin
            errors++;
            $display("FAIL up_reach digits=%h/%h done=%b/%b exp 9959/1", b0.digits, b1.digits, b0.done, b1.done);
        end
        cyc();
        checks++;
        if (b1.digits !== 16'h0000 || b1.done !== 1'b0 || b1.tc !== 1'b0) begin
            errors++;
            $display("FAIL wrap_up digits=%h done=%b tc=%b exp 0000/0/0", b1.digits, b1.done, b1.tc);
        end
        checks++;
        if (b0.digits !== 16'h9959 || b0.done !== 1'b0 || b0.tc !== 1'b1) begin
            errors++;
            $display("FAIL hold_up digits=%h done=%b tc=%b exp 9959/0/1", b0.digits, b0.done, b0.tc);
        end
    endtask

    task automatic test_clamp();
        loadn = 1'b0; data = 16'h0970; en = 1'b0;
        cyc();
        checks++;
        if (b0.digits !== 16'h0950 || b0.load_err !== 1'b1) begin
            errors++;
            $display("FAIL clamp_load digits=%h le=%b exp 0950/1", b0.digits, b0.load_err);
        end
        loadn = 1'b1;
        cyc();
        checks++;
        if (b0.digits !== 16'h0950 || b0.load_err !== 1'b0) begin
            errors++;
            $display("FAIL clamp_pulse digits=%h le=%b exp 0950/0", b0.digits, b0.load_err);
        end
        loadn = 1'b0; data = 16'h0000; en = 1'b1; up = 1'b0;
        cyc();
        checks++;
        if (b0.digits !== 16'h0000 || b0.done !== 1'b0 || b0.load_err !== 1'b0) begin
            errors++;
            $display("FAIL load_zero digits=%h done=%b le=%b exp 0000/0/0", b0.digits, b0.done, b0.load_err);
        end
        loadn = 1'b1; en = 1'b0;
        cyc();
        checks++;
        if (b0.done !== 1'b0) begin
            errors++;
            $display("FAIL load_zero_after done=%b exp 0", b0.done);
        end
    endtask

    task automatic test_priority();
        loadn = 1'b0; data = 16'h1234; en = 1'b1; up = 1'b0;
        cyc();
        checks++;
        if (b0.digits !== 16'h1234) begin
            errors++;
            $display("FAIL prio_load digits=%h exp 1234", b0.digits);
        end
        loadn = 1'b1; en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            up = 1'($urandom);
            cyc();
            checks++;
            if (b0.digits !== 16'h1234 || b1.digits !== 16'h1234 || b0.done !== 1'b0) begin
                errors++;
                $display("FAIL prio_stable cycle=%0d digits=%h/%h done=%b exp 1234 done=0", i, b0.digits, b1.digits, b0.done);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            loadn = $urandom_range(0, 7) != 0;
            case ($urandom_range(0, 3))
                0: data = to_bcd($urandom_range(0, 3));
                1: data = to_bcd(TOT - 1 - $urandom_range(0, 3));
                default: data = 16'($urandom);
            endcase
            en = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 9) == 0) up = ~up;
            cyc();
            checks++;
            if (b0.digits !== to_bcd(n[0]) || b0.done !== ed[0] || b0.load_err !== el[0] || b0.tc !== exp_tc(0) || b0.zero !== (n[0] == 0)) begin
                errors++;
                $display("FAIL rand_hold cycle=%0d digits=%h done=%b le=%b tc=%b zero=%b exp %h/%b/%b/%b/%b",
                         i, b0.digits, b0.done, b0.load_err, b0.tc, b0.zero, to_bcd(n[0]), ed[0], el[0], exp_tc(0), n[0] == 0);
            end
            checks++;
            if (b1.digits !== to_bcd(n[1]) || b1.done !== ed[1] || b1.load_err !== el[1] || b1.tc !== exp_tc(1) || b1.zero !== (n[1] == 0)) begin
                errors++;
                $display("FAIL rand_wrap cycle=%0d digits=%h done=%b le=%b tc=%b zero=%b exp %h/%b/%b/%b/%b",
                         i, b1.digits, b1.done, b1.load_err, b1.tc, b1.zero, to_bcd(n[1]), ed[1], el[1], exp_tc(1), n[1] == 0);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_borrow();
        test_hold();
        test_wrap();
        test_clamp();
        test_priority();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
